sprite_anim_sequencer: RTL

//  Parametrised frame sequencer for animated sprites (bananas, fruit, enemies, DK idle).

---
 rtl/anim_pkg.sv | 28 ++
 rtl/anim_tick_divider.sv | 43 ++++
 rtl/sprite_anim_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/anim_pkg.sv
// Shared types and constants for the sprite animation sequencer.
package anim_pkg;

    typedef enum logic [1:0] {
        ANIM_LOOP     = 2'd0,
        ANIM_PINGPONG = 2'd1,
        ANIM_ONESHOT  = 2'd2,
        ANIM_RSVD     = 2'd3
    } anim_mode_t;

    typedef enum logic {
        ANIM_RUN  = 1'b0,
        ANIM_IDLE = 1'b1
    } anim_state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } anim_dir_t;

    localparam int ANIM_DEFAULT_TICKS = 6_240_001;

    // Register width for a count of n values, never narrower than one bit.
    function automatic int anim_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/anim_tick_divider.sv
// Frame-period prescaler: counts enabled cycles and flags the last one of each period.
module anim_tick_divider
    import anim_pkg::*;
#(
    parameter int FRAME_TICKS = ANIM_DEFAULT_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int CNT_W = anim_width(FRAME_TICKS);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // wrap is the advance term; it is only meaningful while en is high.
    assign wrap = en & (cnt_q == LAST_C);

    // Next count: clr restarts the period, en steps it, otherwise it holds its value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + ONE_C;
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Sprite frame sequencer: loop, ping-pong and one-shot stepping through a frame strip.
// busy mirrors the RUN/IDLE state register and doubles as its observation point.
module sprite_anim_sequencer
    import anim_pkg::*;
#(
    parameter int NUM_FRAMES  = 7,
    parameter int FRAME_TICKS = ANIM_DEFAULT_TICKS,
    parameter int FRAME_W     = anim_width(NUM_FRAMES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               hold,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic [FRAME_W-1:0] frame_num,
    output logic               frame_tick,
    output logic               done,
    output logic               busy
);

    localparam logic [FRAME_W-1:0] LAST_F = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] ONE_F  = FRAME_W'(1);

    logic [FRAME_W-1:0] frame_q, frame_d;
    anim_dir_t          dir_q, dir_d;
    anim_state_t        state_q, state_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               run_en;
    logic               adv;
    anim_mode_t         mode_e;

    assign mode_e = anim_mode_t'(mode);
    assign run_en = (state_q == ANIM_RUN) & enable & ~hold;

    // start restarts the period as well as the frame sequence.
    anim_tick_divider #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_div (
        .clk  (clk),
        .reset(reset),
        .clr  (start),
        .en   (run_en),
        .wrap (adv)
    );

    // Next frame/direction/state plus the one-cycle pulses; start beats a coincident advance.
    always_comb begin
        frame_d = frame_q;
        dir_d   = dir_q;
        state_d = state_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (start) begin
            frame_d = '0;
            dir_d   = DIR_UP;
            state_d = ANIM_RUN;
            tick_d  = (frame_q != '0);
        end else if (adv) begin
            case (mode_e)
                ANIM_PINGPONG: begin
                    tick_d = 1'b1;
                    // A single-frame strip has nowhere to bounce; it just ticks.
                    if (NUM_FRAMES > 1) begin
                        if (dir_q == DIR_UP) begin
                            if (frame_q == LAST_F) begin
                                frame_d = frame_q - ONE_F;
                                dir_d   = DIR_DN;
                            end else begin
                                frame_d = frame_q + ONE_F;
                            end
                        end else begin
                            if (frame_q == '0) begin
                                frame_d = frame_q + ONE_F;
                                dir_d   = DIR_UP;
                            end else begin
                                frame_d = frame_q - ONE_F;
                            end
                        end
                    end
                end
                ANIM_ONESHOT: begin
                    if (frame_q < LAST_F) begin
                        frame_d = frame_q + ONE_F;
                        tick_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ANIM_IDLE;
                    end
                end
                default: begin
                    // LOOP and the reserved encoding wrap forward only.
                    tick_d  = 1'b1;
                    dir_d   = DIR_UP;
                    frame_d = (frame_q == LAST_F) ? '0 : frame_q + ONE_F;
                end
            endcase
        end
    end

    // Frame, direction, state and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            dir_q   <= DIR_UP;
            state_q <= ANIM_RUN;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign frame_num  = frame_q;
    assign frame_tick = tick_q;
    assign done       = done_q;
    assign busy       = (state_q == ANIM_RUN);

endmodule
